// File: rtl/cpu_io_pkg.sv
// ---------------------------------------------------------------------------
// cpu_io_pkg
// Shared types and constants for the CPU I/O bridge.
//   state_t      : request FSM states
//   wr_entry_t   : one queued CPU write (address + data) at default widths
//   FILTER_CNT_W : width of the strobe filter run-length counter
// ---------------------------------------------------------------------------
package cpu_io_pkg;

    localparam int ADDR_W_DEF   = 2;
    localparam int DATA_W_DEF   = 8;
    localparam int FILTER_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/strobe_filter.sv
// ---------------------------------------------------------------------------
// strobe_filter
// Brings one asynchronous active-low CPU strobe into the clk_w domain and
// deglitches it. The filtered output follows the synchronised input only
// after FILTER_LEN consecutive samples that differ from the current output.
// Ports:
//   clk_w     : system clock
//   reset_n_w : asynchronous active-low reset (output resets to 1)
//   raw_n     : raw asynchronous strobe
//   filt_n    : synchronised, filtered strobe
// ---------------------------------------------------------------------------
module strobe_filter
    import cpu_io_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_w,
    input  logic reset_n_w,
    input  logic raw_n,
    output logic filt_n
);

    localparam logic [FILTER_CNT_W-1:0] LAST_CNT = FILTER_CNT_W'(FILTER_LEN - 1);

    logic                    sync_1;
    logic                    sync_2;
    logic [FILTER_CNT_W-1:0] run_cnt;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw_n;
            sync_2 <= sync_1;
        end
    end

    // run_cnt counts samples already seen that disagree with filt_n; the
    // FILTER_LEN-th disagreeing sample flips the output.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            filt_n  <= 1'b1;
            run_cnt <= '0;
        end else if (sync_2 == filt_n) begin
            run_cnt <= '0;
        end else if (run_cnt == LAST_CNT) begin
            filt_n  <= sync_2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// ---------------------------------------------------------------------------
// cpu_io_bridge
// Bridge between the Z80 I/O strobes and the VDP register interface.
// Strobes are synchronised and filtered, writes are queued in a FIFO and
// issued to the VDP under a req/ack handshake. A read is held back until all
// writes queued before it have been accepted.
// Ports:
//   clk_w, reset_n_w      : clock, asynchronous active-low reset
//   csr_n, csw_n          : raw CPU read / write strobes
//   addr_in, din          : raw CPU port address and write data
//   req, wrt, adr, dbo    : registered request to the VDP
//   ack, dbi              : VDP acceptance and read data
//   rd_data, rd_valid     : last read result and its validity
//   fifo_level            : number of queued writes
//   overflow              : sticky, a write was dropped on a full FIFO
//   protocol_err          : sticky, conflicting strobes or overlapping reads
//   clr_err               : synchronous clear of both sticky flags
// ---------------------------------------------------------------------------
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 8,
    parameter int FILTER_LEN = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_w,
    input  logic                          reset_n_w,
    input  logic                          csr_n,
    input  logic                          csw_n,
    input  logic [ADDR_W-1:0]             addr_in,
    input  logic [DATA_W-1:0]             din,
    output logic                          req,
    output logic                          wrt,
    output logic [ADDR_W-1:0]             adr,
    output logic [DATA_W-1:0]             dbo,
    input  logic                          ack,
    input  logic [DATA_W-1:0]             dbi,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          protocol_err,
    input  logic                          clr_err
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // ---------------- input conditioning ----------------
    logic              csr_f;
    logic              csw_f;
    logic              csr_prev;
    logic              csw_prev;
    logic [ADDR_W-1:0] addr_s1;
    logic [ADDR_W-1:0] addr_s2;
    logic [DATA_W-1:0] din_s1;
    logic [DATA_W-1:0] din_s2;

    strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_csr_filter (
        .clk_w     (clk_w),
        .reset_n_w (reset_n_w),
        .raw_n     (csr_n),
        .filt_n    (csr_f)
    );

    strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_csw_filter (
        .clk_w     (clk_w),
        .reset_n_w (reset_n_w),
        .raw_n     (csw_n),
        .filt_n    (csw_f)
    );

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            addr_s1  <= '0;
            addr_s2  <= '0;
            din_s1   <= '0;
            din_s2   <= '0;
            csr_prev <= 1'b1;
            csw_prev <= 1'b1;
        end else begin
            addr_s1  <= addr_in;
            addr_s2  <= addr_s1;
            din_s1   <= din;
            din_s2   <= din_s1;
            csr_prev <= csr_f;
            csw_prev <= csw_f;
        end
    end

    // ---------------- edge classification ----------------
    logic wr_edge;
    logic rd_edge;
    logic rd_rise;
    logic conflict;
    logic wr_cap;
    logic rd_cap;
    logic rd_pend;

    assign wr_edge  = csw_prev & ~csw_f;
    assign rd_edge  = csr_prev & ~csr_f;
    assign rd_rise  = ~csr_prev & csr_f;
    // Both filtered strobes low covers simultaneous edges as well.
    assign conflict = ~csw_f & ~csr_f;
    assign wr_cap   = wr_edge & ~conflict;
    assign rd_cap   = rd_edge & ~conflict & ~rd_pend;

    // ---------------- write FIFO ----------------
    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    entry_t            head;
    logic [PTR_W-1:0]  level_after_pop;

    assign fifo_level      = wr_ptr - rd_ptr;
    assign fifo_empty      = (wr_ptr == rd_ptr);
    assign fifo_full       = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                             (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    // Fullness is taken before any same-cycle pop, so such a push is dropped.
    assign push            = wr_cap & ~fifo_full;
    assign head            = fifo_mem[rd_ptr[IDX_W-1:0]];
    assign level_after_pop = fifo_level - {{(PTR_W-1){1'b0}}, pop};

    always_ff @(posedge clk_w) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= '{addr: addr_s2, data: din_s2};
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ---------------- read tracking and ordering barrier ----------------
    logic [PTR_W-1:0]  barrier;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;

    // barrier counts writes that were queued ahead of the pending read.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            barrier <= '0;
        end else if (rd_cap) begin
            barrier <= level_after_pop;
        end else if (rd_pend && pop && (barrier != '0)) begin
            barrier <= barrier - 1'b1;
        end
    end

    // A csr rising edge wins over a same-cycle completion: the result no
    // longer belongs to an active strobe.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
        end else begin
            if (rd_cap) begin
                rd_pend  <= 1'b1;
                rd_valid <= 1'b0;
                rd_addr  <= addr_s2;
            end
            if (rd_done) begin
                rd_pend  <= 1'b0;
                rd_valid <= 1'b1;
                rd_data  <= dbi;
            end
            if (rd_rise) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // ---------------- request FSM ----------------
    state_t            state;
    state_t            next_state;
    logic              req_nx;
    logic              wrt_nx;
    logic [ADDR_W-1:0] adr_nx;
    logic [DATA_W-1:0] dbo_nx;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state <= IDLE;
            req   <= 1'b0;
            wrt   <= 1'b0;
            adr   <= '0;
            dbo   <= '0;
        end else begin
            state <= next_state;
            req   <= req_nx;
            wrt   <= wrt_nx;
            adr   <= adr_nx;
            dbo   <= dbo_nx;
        end
    end

    // Request fields are loaded on leaving IDLE and held until ack; every
    // ack returns to IDLE, which guarantees a req-low cycle between requests.
    always_comb begin
        next_state = state;
        req_nx     = req;
        wrt_nx     = wrt;
        adr_nx     = adr;
        dbo_nx     = dbo;
        pop        = 1'b0;
        rd_done    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_pend && (barrier == '0)) begin
                    next_state = RD_REQ;
                    req_nx     = 1'b1;
                    wrt_nx     = 1'b0;
                    adr_nx     = rd_addr;
                    dbo_nx     = '0;
                end else if (!fifo_empty) begin
                    next_state = WR_REQ;
                    req_nx     = 1'b1;
                    wrt_nx     = 1'b1;
                    adr_nx     = head.addr;
                    dbo_nx     = head.data;
                end
            end
            WR_REQ: begin
                if (ack) begin
                    pop        = 1'b1;
                    next_state = IDLE;
                    req_nx     = 1'b0;
                    wrt_nx     = 1'b0;
                end
            end
            RD_REQ: begin
                if (ack) begin
                    rd_done    = 1'b1;
                    next_state = IDLE;
                    req_nx     = 1'b0;
                end
            end
            default: begin
                next_state = IDLE;
                req_nx     = 1'b0;
                wrt_nx     = 1'b0;
            end
        endcase
    end

    // ---------------- sticky error flags ----------------
    logic wr_drop;
    logic proto_evt;

    assign wr_drop   = wr_cap & fifo_full;
    assign proto_evt = conflict | (rd_edge & ~conflict & rd_pend);

    // A new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow     <= 1'b0;
                protocol_err <= 1'b0;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (proto_evt) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_io_bridge
// Self-checking bench for cpu_io_bridge. Expected VDP requests are queued
// when CPU strobes are driven and compared as the bridge issues them.
// ---------------------------------------------------------------------------
module tb_cpu_io_bridge;

    logic       clk_w        = 1'b0;
    logic       reset_n_w    = 1'b1;
    logic       csr_n        = 1'b1;
    logic       csw_n        = 1'b1;
    logic [1:0] addr_in      = '0;
    logic [7:0] din          = '0;
    logic       req;
    logic       wrt;
    logic [1:0] adr;
    logic [7:0] dbo;
    logic       ack          = 1'b0;
    logic [7:0] dbi          = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       protocol_err;
    logic       clr_err      = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       wrt;
        logic [1:0] adr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    cpu_io_bridge #(
        .ADDR_W     (2),
        .DATA_W     (8),
        .FILTER_LEN (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_w        (clk_w),
        .reset_n_w    (reset_n_w),
        .csr_n        (csr_n),
        .csw_n        (csw_n),
        .addr_in      (addr_in),
        .din          (din),
        .req          (req),
        .wrt          (wrt),
        .adr          (adr),
        .dbo          (dbo),
        .ack          (ack),
        .dbi          (dbi),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .protocol_err (protocol_err),
        .clr_err      (clr_err)
    );

    always #5 clk_w = ~clk_w;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- stimulus drivers ----------------
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input int low_cycles);
        @(negedge clk_w);
        addr_in = a;
        din     = d;
        csw_n   = 1'b0;
        repeat (low_cycles) @(negedge clk_w);
        csw_n = 1'b1;
        repeat (8) @(negedge clk_w);
    endtask

    task automatic cpu_read(input logic [1:0] a, input int low_cycles);
        @(negedge clk_w);
        addr_in = a;
        csr_n   = 1'b0;
        repeat (low_cycles) @(negedge clk_w);
        csr_n = 1'b1;
        repeat (8) @(negedge clk_w);
    endtask

    task automatic count_reqs(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_w);
            if (req === 1'b1) n++;
        end
    endtask

    // Waits (bounded) for req, holds ack low for 'delay' cycles while
    // watching the request stay stable, then acknowledges it.
    task automatic serve_req(input int delay, input logic [7:0] rdv,
                             output bit got, output bit held, output exp_t obs);
        got  = 1'b0;
        held = 1'b1;
        obs  = '{wrt: 1'b0, adr: 2'd0, data: 8'd0};
        for (int i = 0; i < 100; i++) begin
            if (req === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_w);
        end
        if (got) begin
            obs.wrt  = wrt;
            obs.adr  = adr;
            obs.data = dbo;
            for (int i = 0; i < delay; i++) begin
                @(negedge clk_w);
                if (req !== 1'b1 || wrt !== obs.wrt || adr !== obs.adr ||
                    (obs.wrt && dbo !== obs.data)) held = 1'b0;
            end
            dbi = rdv;
            ack = 1'b1;
            @(negedge clk_w);
            ack = 1'b0;
            if (req !== 1'b0) held = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset_n_w = 1'b0;
        repeat (3) @(negedge clk_w);
        total++;
        if (req !== 1'b0 || wrt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_req: req=%b wrt=%b, expected 0 0", req, wrt);
        end
        total++;
        if (adr !== 2'd0 || dbo !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_bus: adr=%0d dbo=%h, expected 0 00", adr, dbo);
        end
        total++;
        if (rd_data !== 8'd0 || rd_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rd: rd_data=%h rd_valid=%b, expected 00 0", rd_data, rd_valid);
        end
        total++;
        if (fifo_level !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_level: fifo_level=%0d, expected 0", fifo_level);
        end
        total++;
        if (overflow !== 1'b0 || protocol_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: overflow=%b protocol_err=%b, expected 0 0", overflow, protocol_err);
        end
        reset_n_w = 1'b1;
        repeat (3) @(negedge clk_w);
    endtask

    task automatic test_single_write();
        exp_t e;
        exp_t obs;
        bit   got;
        bit   held;
        int   n;
        cpu_write(2'd1, 8'hA5, 10);
        exp_q.push_back('{wrt: 1'b1, adr: 2'd1, data: 8'hA5});
        e = exp_q.pop_front();
        serve_req(3, 8'h00, got, held, obs);
        total++;
        if (!got || obs.wrt !== e.wrt || obs.adr !== e.adr || obs.data !== e.data) begin
            bad++;
            $display("[TB] FAIL single_write_req: got=%0b wrt=%b adr=%0d dbo=%h, expected wrt=%b adr=%0d dbo=%h",
                     got, obs.wrt, obs.adr, obs.data, e.wrt, e.adr, e.data);
        end
        total++;
        if (!held) begin
            bad++;
            $display("[TB] FAIL single_write_hold: stable=%0b, expected 1", held);
        end
        count_reqs(10, n);
        total++;
        if (n !== 0 || fifo_level !== 3'd0) begin
            bad++;
            $display("[TB] FAIL single_write_after: extra req cycles=%0d fifo_level=%0d, expected 0 0", n, fifo_level);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        exp_t obs;
        bit   got;
        bit   held;
        int   n;
        cpu_write(2'd2, 8'h3C, 2);
        count_reqs(10, n);
        total++;
        if (n !== 0 || fifo_level !== 3'd0) begin
            bad++;
            $display("[TB] FAIL glitch_short: req cycles=%0d fifo_level=%0d, expected 0 0", n, fifo_level);
        end
        cpu_write(2'd2, 8'h3C, 5);
        exp_q.push_back('{wrt: 1'b1, adr: 2'd2, data: 8'h3C});
        e = exp_q.pop_front();
        serve_req(0, 8'h00, got, held, obs);
        total++;
        if (!got || obs.wrt !== e.wrt || obs.adr !== e.adr || obs.data !== e.data) begin
            bad++;
            $display("[TB] FAIL glitch_long: got=%0b wrt=%b adr=%0d dbo=%h, expected wrt=%b adr=%0d dbo=%h",
                     got, obs.wrt, obs.adr, obs.data, e.wrt, e.adr, e.data);
        end
        count_reqs(10, n);
        total++;
        if (n !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_once: extra req cycles=%0d, expected 0", n);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        exp_t obs;
        bit   got;
        bit   held;
        int   n;
        for (int i = 0; i < 5; i++) begin
            cpu_write(2'(i), 8'h40 + 8'(i), 6);
            if (i < 4) exp_q.push_back('{wrt: 1'b1, adr: 2'(i), data: 8'h40 + 8'(i)});
        end
        total++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflow_full: fifo_level=%0d overflow=%b, expected 4 1", fifo_level, overflow);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            serve_req(0, 8'h00, got, held, obs);
            total++;
            if (!got || !held || obs.wrt !== e.wrt || obs.adr !== e.adr || obs.data !== e.data) begin
                bad++;
                $display("[TB] FAIL overflow_drain: got=%0b held=%0b wrt=%b adr=%0d dbo=%h, expected wrt=%b adr=%0d dbo=%h",
                         got, held, obs.wrt, obs.adr, obs.data, e.wrt, e.adr, e.data);
            end
        end
        count_reqs(10, n);
        total++;
        if (n !== 0 || fifo_level !== 3'd0 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflow_lost: req cycles=%0d fifo_level=%0d overflow=%b, expected 0 0 1",
                     n, fifo_level, overflow);
        end
        @(negedge clk_w);
        clr_err = 1'b1;
        @(negedge clk_w);
        clr_err = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overflow_clear: overflow=%b, expected 0", overflow);
        end
    endtask

    task automatic test_ordering();
        exp_t e;
        exp_t obs;
        bit   got;
        bit   held;
        cpu_write(2'd1, 8'h11, 6);
        exp_q.push_back('{wrt: 1'b1, adr: 2'd1, data: 8'h11});
        cpu_write(2'd2, 8'h22, 6);
        exp_q.push_back('{wrt: 1'b1, adr: 2'd2, data: 8'h22});
        cpu_read(2'd0, 6);
        exp_q.push_back('{wrt: 1'b0, adr: 2'd0, data: 8'h5C});
        cpu_write(2'd3, 8'h33, 6);
        exp_q.push_back('{wrt: 1'b1, adr: 2'd3, data: 8'h33});
        total++;
        if (fifo_level !== 3'd3) begin
            bad++;
            $display("[TB] FAIL order_level: fifo_level=%0d, expected 3", fifo_level);
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            serve_req(2, e.data, got, held, obs);
            total++;
            if (!got || !held || obs.wrt !== e.wrt || obs.adr !== e.adr ||
                (e.wrt && obs.data !== e.data)) begin
                bad++;
                $display("[TB] FAIL order_seq%0d: got=%0b held=%0b wrt=%b adr=%0d dbo=%h, expected wrt=%b adr=%0d dbo=%h",
                         i, got, held, obs.wrt, obs.adr, obs.data, e.wrt, e.adr, e.data);
            end
            if (i == 1) begin
                total++;
                if (rd_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL order_early_valid: rd_valid=%b, expected 0", rd_valid);
                end
            end
            if (i == 2) begin
                total++;
                if (rd_data !== 8'h5C || rd_valid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL order_read_data: rd_data=%h rd_valid=%b, expected 5c 1", rd_data, rd_valid);
                end
            end
        end
    endtask

    task automatic test_protocol();
        exp_t e;
        exp_t obs;
        bit   got;
        bit   held;
        int   n1;
        int   n2;
        @(negedge clk_w);
        addr_in = 2'd1;
        csr_n   = 1'b0;
        csw_n   = 1'b0;
        count_reqs(8, n1);
        csr_n = 1'b1;
        csw_n = 1'b1;
        count_reqs(8, n2);
        total++;
        if ((n1 + n2) !== 0 || protocol_err !== 1'b1 || fifo_level !== 3'd0) begin
            bad++;
            $display("[TB] FAIL proto_both: req cycles=%0d protocol_err=%b fifo_level=%0d, expected 0 1 0",
                     n1 + n2, protocol_err, fifo_level);
        end
        @(negedge clk_w);
        clr_err = 1'b1;
        @(negedge clk_w);
        clr_err = 1'b0;
        total++;
        if (protocol_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL proto_clear: protocol_err=%b, expected 0", protocol_err);
        end
        cpu_read(2'd2, 6);
        exp_q.push_back('{wrt: 1'b0, adr: 2'd2, data: 8'h77});
        cpu_read(2'd1, 6);
        total++;
        if (protocol_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL proto_second_read: protocol_err=%b, expected 1", protocol_err);
        end
        e = exp_q.pop_front();
        serve_req(1, e.data, got, held, obs);
        total++;
        if (!got || obs.wrt !== e.wrt || obs.adr !== e.adr || rd_data !== e.data) begin
            bad++;
            $display("[TB] FAIL proto_read: got=%0b wrt=%b adr=%0d rd_data=%h, expected wrt=%b adr=%0d rd_data=%h",
                     got, obs.wrt, obs.adr, rd_data, e.wrt, e.adr, e.data);
        end
        count_reqs(15, n1);
        total++;
        if (n1 !== 0) begin
            bad++;
            $display("[TB] FAIL proto_one_read: extra req cycles=%0d, expected 0", n1);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t obs;
        bit   got;
        bit   held;
        int   n;
        for (int i = 0; i < 3; i++) begin
            cpu_write(2'(i), 8'hC0 + 8'(i), 6);
        end
        total++;
        if (req !== 1'b1 || wrt !== 1'b1 || fifo_level !== 3'd3) begin
            bad++;
            $display("[TB] FAIL rstmid_setup: req=%b wrt=%b fifo_level=%0d, expected 1 1 3", req, wrt, fifo_level);
        end
        #2 reset_n_w = 1'b0;
        #1;
        total++;
        if (req !== 1'b0 || fifo_level !== 3'd0) begin
            bad++;
            $display("[TB] FAIL rstmid_async: req=%b fifo_level=%0d, expected 0 0", req, fifo_level);
        end
        @(negedge clk_w);
        reset_n_w = 1'b1;
        count_reqs(20, n);
        total++;
        if (n !== 0 || fifo_level !== 3'd0) begin
            bad++;
            $display("[TB] FAIL rstmid_quiet: req cycles=%0d fifo_level=%0d, expected 0 0", n, fifo_level);
        end
        cpu_write(2'd2, 8'h9E, 6);
        exp_q.push_back('{wrt: 1'b1, adr: 2'd2, data: 8'h9E});
        e = exp_q.pop_front();
        serve_req(0, 8'h00, got, held, obs);
        total++;
        if (!got || obs.wrt !== e.wrt || obs.adr !== e.adr || obs.data !== e.data) begin
            bad++;
            $display("[TB] FAIL rstmid_resume: got=%0b wrt=%b adr=%0d dbo=%h, expected wrt=%b adr=%0d dbo=%h",
                     got, obs.wrt, obs.adr, obs.data, e.wrt, e.adr, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_glitch();
        test_overflow();
        test_ordering();
        test_protocol();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
